// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module   : fifo_wr_arbiter_if
// Brief    : Requester handshake and fifo write-port bundle for fifo_wr_arbiter.
//            Stats ports exist only when FIFO_ARB_STATS_EN is defined.
// Revision : 1.0
//==============================================================================
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 128
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [DATA_WIDTH-1:0]         fifo_wr_data_o;
  logic                          fifo_wr_en_o;
  logic                          fifo_full_i;
  logic [NUM_REQ-1:0]            grant_o;
  logic                          busy_o;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*32-1:0]         beat_count_o;
  logic [31:0]                   stall_count_o;

  modport master (
    input  req_valid_i, req_data_i, fifo_full_i,
    output req_ready_o, fifo_wr_data_o, fifo_wr_en_o, grant_o, busy_o,
    output beat_count_o, stall_count_o
  );
  modport slave (
    output req_valid_i, req_data_i, fifo_full_i,
    input  req_ready_o, fifo_wr_data_o, fifo_wr_en_o, grant_o, busy_o,
    input  beat_count_o, stall_count_o
  );
`else
  modport master (
    input  req_valid_i, req_data_i, fifo_full_i,
    output req_ready_o, fifo_wr_data_o, fifo_wr_en_o, grant_o, busy_o
  );
  modport slave (
    output req_valid_i, req_data_i, fifo_full_i,
    input  req_ready_o, fifo_wr_data_o, fifo_wr_en_o, grant_o, busy_o
  );
`endif
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter sharing one fifo write port among
//            NUM_REQ valid/ready requesters. FIFO_ARB_STATS_EN adds counters.
// Revision : 1.0
//==============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BURST  = 8
) (
  input  wire logic         clock,
  input  wire logic         reset,
  fifo_wr_arbiter_if.master bus
);
  localparam int                     c_owner_w   = $clog2(NUM_REQ);
  localparam int                     c_cnt_w     = $clog2(MAX_BURST + 1);
  localparam logic [c_owner_w-1:0]   c_last_idx  = c_owner_w'(NUM_REQ - 1);
  localparam logic [c_owner_w:0]     c_num_req   = (c_owner_w + 1)'(NUM_REQ);
  localparam logic [c_cnt_w-1:0]     c_max_burst = c_cnt_w'(MAX_BURST);
  localparam logic [NUM_REQ-1:0]     c_one       = NUM_REQ'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_owner_w-1:0]  r_owner, w_owner_nxt;
  logic [c_owner_w-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [c_cnt_w-1:0]    r_beat_cnt, w_beat_cnt_nxt;
  logic [c_owner_w:0]    w_scan_idx;
  logic [c_owner_w-1:0]  w_pick_idx;
  logic                  w_pick_vld;
  logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];
  logic [NUM_REQ-1:0]    w_onehot;
  logic                  w_burst, w_owner_vld, w_accept, w_last_beat, w_release;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_data[gi] = bus.req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scan_idx = {1'b0, r_rr_ptr} + (c_owner_w + 1)'(i);
      if (w_scan_idx >= c_num_req) begin
        w_scan_idx = w_scan_idx - c_num_req;
      end
      if (!w_pick_vld && bus.req_valid_i[w_scan_idx[c_owner_w-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_scan_idx[c_owner_w-1:0];
      end
    end
  end

  assign w_burst     = (r_state == S_BURST);
  assign w_onehot    = c_one << r_owner;
  assign w_owner_vld = bus.req_valid_i[r_owner];
  assign w_accept    = w_burst & w_owner_vld & ~bus.fifo_full_i;
  assign w_last_beat = w_accept && ((r_beat_cnt + c_cnt_w'(1)) == c_max_burst);
  // A full fifo freezes the burst: the owner cannot release while stalled.
  assign w_release   = w_burst & ~w_owner_vld & ~bus.fifo_full_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt    = S_BURST;
          w_owner_nxt    = w_pick_idx;
          w_beat_cnt_nxt = '0;
        end
      end
      S_BURST: begin
        if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + c_cnt_w'(1);
        end
        if (w_last_beat || w_release) begin
          w_state_nxt  = S_IDLE;
          w_rr_ptr_nxt = (r_owner == c_last_idx) ? '0 : r_owner + c_owner_w'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  assign bus.grant_o        = w_burst ? w_onehot : '0;
  assign bus.busy_o         = w_burst;
  assign bus.req_ready_o    = (w_burst && !bus.fifo_full_i) ? w_onehot : '0;
  assign bus.fifo_wr_en_o   = w_accept;
  assign bus.fifo_wr_data_o = w_burst ? w_req_data[r_owner] : '0;

`ifdef FIFO_ARB_STATS_EN
  logic [31:0] r_stall_count;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_beat_count
      logic [31:0] r_count;
      always_ff @(posedge clock) begin
        if (reset) begin
          r_count <= '0;
        end else if (bus.req_valid_i[gi] && bus.req_ready_o[gi]) begin
          r_count <= r_count + 32'd1;
        end
      end
      assign bus.beat_count_o[gi*32 +: 32] = r_count;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_burst && bus.fifo_full_i) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign bus.stall_count_o = r_stall_count;
`endif
endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the `fifo` block (DEPTH_WIDTH/DATA_WIDTH parameterised) among N requesters. Each requester uses a valid/ready handshake. The arbiter grants the port in bursts, muxes the granted requester's data onto the fifo write port, and applies fifo backpressure. It sits between producer blocks and the fifo instance in `top`.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 128, data width; matches the fifo DATA_WIDTH.
- MAX_BURST, 8, maximum accepted beats per grant (1..256).

Ports:
- clock  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester data valid.
- req_data_i  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  output  NUM_REQ  per-requester accept; a beat transfers when valid and ready are both high.
- fifo_wr_data_o  output  DATA_WIDTH  to fifo wr_data_i.
- fifo_wr_en_o  output  1  to fifo wr_en_i.
- fifo_full_i  input  1  from fifo full_o.
- grant_o  output  NUM_REQ  one-hot current owner; zero when idle.
- busy_o  output  1  high in BURST state.

Behaviour:
- State machine with two states: IDLE and BURST.
- Registered state:
  - state
  - owner index (clog2(NUM_REQ) bits)
  - rr_ptr, the highest-priority index
  - beat_cnt (clog2(MAX_BURST+1) bits)
- Reset values:
  - state = IDLE, owner = 0, rr_ptr = 0, beat_cnt = 0.
  - All outputs are 0: grant_o = 0, busy_o = 0, req_ready_o = 0, fifo_wr_en_o = 0, fifo_wr_data_o = 0.
- IDLE:
  - If any req_valid_i is high, select the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Next cycle: owner = that index, beat_cnt = 0, state = BURST.
  - There is one cycle of arbitration latency. No beat is accepted in IDLE.
- BURST outputs, all combinational from registered state:
  - grant_o = onehot(owner).
  - busy_o = 1.
  - req_ready_o[owner] = !fifo_full_i; all other bits are 0.
  - fifo_wr_en_o = req_valid_i[owner] & !fifo_full_i.
  - fifo_wr_data_o = req_data_i[owner]. When not in BURST, fifo_wr_data_o is 0.
- Beat accepted (fifo_wr_en_o = 1): beat_cnt increments.
- Burst termination, checked each cycle in BURST:
  - Condition (a): an accepted beat brings beat_cnt+1 to MAX_BURST.
  - Condition (b): req_valid_i[owner] = 0 while fifo_full_i = 0, meaning the requester released the port.
  - On either condition: next state = IDLE, rr_ptr = (owner+1) mod NUM_REQ, grant_o drops the next cycle.
- Full backpressure: while fifo_full_i = 1 in BURST:
  - No beat is accepted, no termination occurs, beat_cnt holds.
  - Owner keeps the grant even if its valid drops, so the owner is not lost mid-burst.
- Simultaneous full and valid: the fifo_full_i sample takes precedence and there is no write. The arbiter never asserts wr_en while full, so the fifo never sees a write-when-full.
- Wrap-around: rr_ptr is computed modulo NUM_REQ. With NUM_REQ = 4 and owner = 3, next rr_ptr = 0.
- Fairness: requesters continuously valid are served in rotating order 0,1,2,3,0,... with MAX_BURST beats each.
- Reset mid-burst:
  - Returns to the reset values on the next edge.
  - Beats already written remain in the fifo; the fifo resets only on its own reset.
- Requesters must hold data stable while valid and not ready; the arbiter does not check this.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- When defined, adds output beat_count_o, NUM_REQ*32 bits:
  - Per-requester 32-bit counters of accepted beats.
  - Increment when req_valid_i[i] & req_ready_o[i].
  - Wrap at 2^32 to 0; cleared by reset.
- Also adds output stall_count_o, 32 bits: counts cycles in BURST with fifo_full_i = 1.
- When undefined, neither port nor counters exist. Core behaviour is identical in both builds.

Test Plan:
1. Reset, then req_valid_i = 4'b0001 for 3 beats (data 3, 4, 5), full = 0.
   - grant_o = 0001 one cycle after valid.
   - fifo_wr_en_o is high for 3 cycles with data 3, 4, 5.
   - Release goes to IDLE; rr_ptr = 1.
2. All four requesters valid continuously, MAX_BURST = 8.
   - Grants go 0, 1, 2, 3, 0, with exactly 8 writes each.
   - There is one idle arbitration cycle between bursts.
3. Owner 2 mid-burst after 3 beats; fifo_full_i = 1 for 5 cycles.
   - No writes and req_ready_o = 0 during the 5 cycles.
   - grant_o holds 0100 and beat_cnt holds 3.
   - After full drops, exactly 5 more beats are written before release.
4. Owner 3 finishes a burst while requesters 0 and 3 are valid.
   - Next grant = 0 (wrap-around), not 3.
5. Assert reset during a burst at beat 4.
   - The next cycle shows grant_o = 0, fifo_wr_en_o = 0, busy_o = 0.
   - A re-arbitration with all valid grants requester 0 first.
6. With FIFO_ARB_STATS_EN, run scenario 2 for two full rounds plus scenario 3's 5-cycle stall.
   - beat_count_o = 16 per requester.
   - stall_count_o = 5.
